// File: rtl/zap_irq_fiq_controller.sv
// IRQ/FIQ front-end for exception entry: synchronizes and masks the raw lines, prefers FIQ over IRQ,
// holds one request until the register file acks it, then blocks re-arbitration for a flush window.
module zap_irq_fiq_controller #(
    parameter int SYNC_STAGES  = 2,
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_WDT      = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_irq_raw,
    input  logic               i_fiq_raw,
    input  logic [31:0]        i_cpsr,
    input  logic               i_irq_ack,
    input  logic               i_fiq_ack,
    output logic               o_irq,
    output logic               o_fiq,
    output logic               o_busy,
    output logic               o_spurious_ack,
    output logic [CNT_WDT-1:0] o_irq_taken,
    output logic [CNT_WDT-1:0] o_fiq_taken
);

    localparam int   FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam int   FLUSH_W    = (FLUSH_LOAD > 1) ? $clog2(FLUSH_LOAD + 1) : 1;
    localparam logic FLUSH_EN   = (FLUSH_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_FIQ = 2'd1,
        REQ_IRQ = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
    logic [SYNC_STAGES-1:0] fiq_sync_q, fiq_sync_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_WDT-1:0]   irq_taken_q, irq_taken_d;
    logic [CNT_WDT-1:0]   fiq_taken_q, fiq_taken_d;
    logic                 spurious_q, spurious_d;
    logic                 irq_s, fiq_s, irq_ok_s, fiq_ok_s;
    logic                 cpsr_unused_s;

    assign irq_s         = irq_sync_q[SYNC_STAGES-1];
    assign fiq_s         = fiq_sync_q[SYNC_STAGES-1];
    assign fiq_ok_s      = fiq_s & ~i_cpsr[6];
    assign irq_ok_s      = irq_s & ~i_cpsr[7];
    assign cpsr_unused_s = ^{i_cpsr[31:8], i_cpsr[5:0]};

    // Next-state, flush countdown, taken counters and sticky spurious-ack flag.
    always_comb begin
        irq_sync_d  = {irq_sync_q[SYNC_STAGES-2:0], i_irq_raw};
        fiq_sync_d  = {fiq_sync_q[SYNC_STAGES-2:0], i_fiq_raw};
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        irq_taken_d = irq_taken_q;
        fiq_taken_d = fiq_taken_q;
        spurious_d  = spurious_q
                    | (i_fiq_ack & (state_q != REQ_FIQ))
                    | (i_irq_ack & (state_q != REQ_IRQ));

        case (state_q)
            IDLE: begin
                if (fiq_ok_s) begin
                    state_d = REQ_FIQ;
                end else if (irq_ok_s) begin
                    state_d = REQ_IRQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ_FIQ: begin
                if (i_fiq_ack) begin
                    fiq_taken_d = fiq_taken_q + CNT_WDT'(1'b1);
                    flush_cnt_d = FLUSH_W'(FLUSH_LOAD);
                    state_d     = FLUSH_EN ? FLUSH : IDLE;
                end else if (!fiq_ok_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ_FIQ;
                end
            end
            REQ_IRQ: begin
                // The ack wins even when a FIQ becomes eligible in the same cycle.
                if (i_irq_ack) begin
                    irq_taken_d = irq_taken_q + CNT_WDT'(1'b1);
                    flush_cnt_d = FLUSH_W'(FLUSH_LOAD);
                    state_d     = FLUSH_EN ? FLUSH : IDLE;
                end else if (fiq_ok_s) begin
                    state_d = REQ_FIQ;
                end else if (!irq_ok_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ_IRQ;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(1'b0)) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, synchronizer and counter registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            irq_sync_q  <= '0;
            fiq_sync_q  <= '0;
            flush_cnt_q <= '0;
            irq_taken_q <= '0;
            fiq_taken_q <= '0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_sync_q  <= irq_sync_d;
            fiq_sync_q  <= fiq_sync_d;
            flush_cnt_q <= flush_cnt_d;
            irq_taken_q <= irq_taken_d;
            fiq_taken_q <= fiq_taken_d;
            spurious_q  <= spurious_d;
        end
    end

    assign o_fiq          = (state_q == REQ_FIQ);
    assign o_irq          = (state_q == REQ_IRQ);
    assign o_busy         = (state_q != IDLE);
    assign o_spurious_ack = spurious_q;
    assign o_irq_taken    = irq_taken_q;
    assign o_fiq_taken    = fiq_taken_q;

endmodule
